// File: rtl/ppl_frame_ctrl_if.sv
// rtl/ppl_frame_ctrl_if.sv - pipeline entry slot handshake between ray ring and frame scheduler
interface ppl_frame_ctrl_if;
   logic       exit_valid;
   logic       exit_hit;
   logic [4:0] block_cnt_out;
   logic       next_en;
   logic       scanner_stop;
   logic       entry_valid;
   logic       retire;

   modport master (
      output exit_valid,
      output exit_hit,
      output block_cnt_out,
      input  next_en,
      input  scanner_stop,
      input  entry_valid,
      input  retire
   );

   modport slave (
      input  exit_valid,
      input  exit_hit,
      input  block_cnt_out,
      output next_en,
      output scanner_stop,
      output entry_valid,
      output retire
   );
endinterface

// File: rtl/ppl_frame_ctrl.sv
// rtl/ppl_frame_ctrl.sv - frame scheduler for the recirculating ray-march pipeline
module ppl_frame_ctrl #(
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720,
   parameter int PPL_DEPTH  = 16,
   parameter int MAX_BLOCKS = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic [15:0]        p_pos_x,
   input  logic [15:0]        p_pos_y,
   input  logic [15:0]        p_pos_z,
   input  logic signed [15:0] p_angle_x,
   input  logic signed [15:0] p_angle_y,
   ppl_frame_ctrl_if.slave    slot,
   output logic [15:0]        f_pos_x,
   output logic [15:0]        f_pos_y,
   output logic [15:0]        f_pos_z,
   output logic signed [15:0] f_angle_x,
   output logic signed [15:0] f_angle_y,
   output logic               frame_busy,
   output logic               frame_done,
   output logic               frame_overrun,
   output logic [19:0]        issued_cnt,
   output logic [7:0]         inflight_cnt
);

   localparam logic [19:0] TOTAL     = 20'(H_DISP * V_DISP);
   localparam logic [4:0]  MAX_B     = 5'(MAX_BLOCKS);
   localparam logic [7:0]  DEPTH_CAP = 8'(PPL_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   retire;
   logic   free;
   logic   issue;
   logic   latch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      retire    = 1'b0;
      free      = 1'b0;
      issue     = 1'b0;
      latch     = 1'b0;
      state_nxt = state;

      // A slot is reusable when empty or when its ray terminates on this pass.
      retire = slot.exit_valid & (slot.exit_hit | (slot.block_cnt_out >= MAX_B));
      free   = ~slot.exit_valid | retire;
      issue  = free & (state == ISSUE) & (issued_cnt < TOTAL);

      case (state)
         IDLE: begin
            if (frame_start) begin
               latch     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (issued_cnt == TOTAL) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_cnt == 8'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign slot.retire       = retire;
   assign slot.next_en      = free;
   assign slot.scanner_stop = free & ~issue;
   assign slot.entry_valid  = (slot.exit_valid & ~retire) | issue;

   assign frame_busy = (state == ISSUE) || (state == DRAIN);
   assign frame_done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         f_pos_x       <= '0;
         f_pos_y       <= '0;
         f_pos_z       <= '0;
         f_angle_x     <= '0;
         f_angle_y     <= '0;
         frame_overrun <= 1'b0;
         issued_cnt    <= '0;
         inflight_cnt  <= '0;
      end else begin
         // Pose stays frozen for the whole frame so every ray sees one camera.
         if (latch) begin
            f_pos_x   <= p_pos_x;
            f_pos_y   <= p_pos_y;
            f_pos_z   <= p_pos_z;
            f_angle_x <= p_angle_x;
            f_angle_y <= p_angle_y;
         end

         if (latch) begin
            issued_cnt <= '0;
         end else if (issue) begin
            issued_cnt <= issued_cnt + 20'd1;
         end

         if (issue && !retire && (inflight_cnt < DEPTH_CAP)) begin
            inflight_cnt <= inflight_cnt + 8'd1;
         end else if (retire && !issue && (inflight_cnt != 8'd0)) begin
            inflight_cnt <= inflight_cnt - 8'd1;
         end

         if (frame_start && (state != IDLE)) begin
            frame_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ppl_frame_ctrl.sv
// tb/tb_ppl_frame_ctrl.sv - directed bench for ppl_frame_ctrl with a 3-slot ring model
module tb_ppl_frame_ctrl;
   localparam int DEPTH = 3;
   localparam int TOT   = 8;
   localparam int MAXB  = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               frame_start = 1'b0;
   logic [15:0]        p_pos_x, p_pos_y, p_pos_z;
   logic signed [15:0] p_angle_x, p_angle_y;
   logic [15:0]        f_pos_x, f_pos_y, f_pos_z;
   logic signed [15:0] f_angle_x, f_angle_y;
   logic               frame_busy, frame_done, frame_overrun;
   logic [19:0]        issued_cnt;
   logic [7:0]         inflight_cnt;

   ppl_frame_ctrl_if slot ();

   ppl_frame_ctrl #(
      .H_DISP(4), .V_DISP(2), .PPL_DEPTH(DEPTH), .MAX_BLOCKS(MAXB)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
      .p_angle_x(p_angle_x), .p_angle_y(p_angle_y),
      .slot(slot),
      .f_pos_x(f_pos_x), .f_pos_y(f_pos_y), .f_pos_z(f_pos_z),
      .f_angle_x(f_angle_x), .f_angle_y(f_angle_y),
      .frame_busy(frame_busy), .frame_done(frame_done), .frame_overrun(frame_overrun),
      .issued_cnt(issued_cnt), .inflight_cnt(inflight_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit v;
      int cnt;
   } slot_t;

   slot_t ring [DEPTH];
   int    ptr, cyc, m_issued, m_inflight, m_retired, last_ret, hit_lap;
   bit    m_busy, m_overrun;
   bit    e_retire, e_free, e_issue, e_ev, e_done, arr_v;
   int    arr_cnt, e_inflight;
   logic  o_retire, o_next_en, o_stop, o_ev, o_done, o_busy, o_over;
   logic [19:0] o_issued;
   logic [7:0]  o_inflight;
   logic [15:0] o_fpx;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ring[i] = '{v: 1'b0, cnt: 0};
      ptr = 0; cyc = 0; m_issued = 0; m_inflight = 0; m_retired = 0;
      last_ret = -100; m_busy = 1'b0; m_overrun = 1'b0;
   endtask

   // One slot time: drive the arriving slot, sample at negedge, advance the ring model.
   task automatic step(input bit fs);
      arr_v   = ring[ptr].v;
      arr_cnt = ring[ptr].cnt;
      slot.exit_valid    = arr_v;
      slot.exit_hit      = arr_v ? (arr_cnt >= hit_lap) : 1'b1;
      slot.block_cnt_out = arr_v ? 5'(arr_cnt) : 5'd31;
      frame_start        = fs;
      e_retire   = arr_v && ((arr_cnt >= hit_lap) || (arr_cnt >= MAXB));
      e_free     = !arr_v || e_retire;
      e_issue    = e_free && m_busy && (m_issued < TOT);
      e_ev       = (arr_v && !e_retire) || e_issue;
      e_done     = (cyc == last_ret + 2);
      e_inflight = m_inflight;
      @(negedge clk);
      o_retire = slot.retire; o_next_en = slot.next_en; o_stop = slot.scanner_stop;
      o_ev = slot.entry_valid; o_done = frame_done; o_busy = frame_busy;
      o_over = frame_overrun; o_issued = issued_cnt; o_inflight = inflight_cnt; o_fpx = f_pos_x;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (fs && !m_busy) begin
         m_busy = 1'b1; m_issued = 0; m_retired = 0; last_ret = -100;
      end else if (fs) begin
         m_overrun = 1'b1;
      end
      if (e_done) m_busy = 1'b0;
      if (e_issue) m_issued++;
      m_inflight += int'(e_issue) - int'(e_retire);
      if (e_retire) begin
         m_retired++;
         if (m_retired == TOT) last_ret = cyc;
      end
      if (e_ev) ring[ptr] = e_issue ? '{v: 1'b1, cnt: 1} : '{v: 1'b1, cnt: arr_cnt + 1};
      else ring[ptr] = '{v: 1'b0, cnt: 0};
      ptr = (ptr + 1) % DEPTH;
      cyc++;
   endtask

   task automatic test_reset();
      slot.exit_valid = 1'b0; slot.exit_hit = 1'b0; slot.block_cnt_out = 5'd0;
      p_pos_x = 16'hBEEF; p_pos_y = 16'h0002; p_pos_z = 16'h0003;
      p_angle_x = -16'sd5; p_angle_y = 16'sd7;
      rst = 1'b1; frame_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; frame_start = 1'b0;
      model_reset();
      checks++;
      if (frame_busy !== 1'b0 || frame_done !== 1'b0 || frame_overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b done=%b overrun=%b required 000", frame_busy, frame_done, frame_overrun);
      end
      checks++;
      if (issued_cnt !== 20'd0 || inflight_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_counters issued=%0d inflight=%0d required 0 0", issued_cnt, inflight_cnt);
      end
      checks++;
      if (f_pos_x !== 16'h0000 || f_angle_x !== 16'sd0) begin
         errors++;
         $display("FAIL reset_beats_start f_pos_x=%h f_angle_x=%0d required 0000 0", f_pos_x, f_angle_x);
      end
   endtask

   task automatic test_frame();
      int rets = 0, dones = 0, simul = 0;
      bit finished = 1'b0;
      hit_lap = 2;
      p_pos_x = 16'h1000;
      step(1'b0);
      checks++;
      if (o_next_en !== 1'b1 || o_stop !== 1'b1 || o_ev !== 1'b0) begin
         errors++;
         $display("FAIL idle_bubble next_en=%b stop=%b entry_valid=%b required 1 1 0", o_next_en, o_stop, o_ev);
      end
      step(1'b1);
      for (int i = 0; i < 200 && !finished; i++) begin
         p_pos_x = 16'h2000 + 16'(i);
         step(1'b0);
         checks++;
         if (o_retire !== e_retire || o_next_en !== e_free || o_stop !== (e_free && !e_issue) || o_ev !== e_ev) begin
            errors++;
            $display("FAIL slot_decode cyc=%0d ret/nen/stop/ev=%b%b%b%b required %b%b%b%b", cyc,
                     o_retire, o_next_en, o_stop, o_ev, e_retire, e_free, e_free && !e_issue, e_ev);
         end
         checks++;
         if (o_inflight !== 8'(e_inflight) || o_inflight > 8'(DEPTH)) begin
            errors++;
            $display("FAIL inflight cyc=%0d got=%0d required %0d (bound %0d)", cyc, o_inflight, e_inflight, DEPTH);
         end
         checks++;
         if (o_fpx !== 16'h1000) begin
            errors++;
            $display("FAIL pose_frozen f_pos_x=%h required 1000", o_fpx);
         end
         checks++;
         if (o_done !== e_done) begin
            errors++;
            $display("FAIL done_timing cyc=%0d frame_done=%b required %b", cyc, o_done, e_done);
         end
         if (o_retire === 1'b1) rets++;
         if (o_retire === 1'b1 && o_ev === 1'b1 && o_next_en === 1'b1) simul++;
         if (o_done === 1'b1) begin
            dones++;
            finished = 1'b1;
         end
      end
      checks++;
      if (rets != TOT || dones != 1) begin
         errors++;
         $display("FAIL frame_totals retires=%0d dones=%0d required %0d 1", rets, dones, TOT);
      end
      checks++;
      if (frame_busy !== 1'b0 || issued_cnt !== 20'(TOT) || f_angle_x !== -16'sd5) begin
         errors++;
         $display("FAIL frame_end busy=%b issued=%0d f_angle_x=%0d required 0 %0d -5", frame_busy, issued_cnt, f_angle_x, TOT);
      end
      checks++;
      if (simul < 1) begin
         errors++;
         $display("FAIL retire_and_issue events=%0d required at least 1", simul);
      end
   endtask

   task automatic test_block_limit();
      int seen3 = 0, seen4 = 0;
      bit finished = 1'b0;
      hit_lap = 99;
      step(1'b1);
      for (int i = 0; i < 300 && !finished; i++) begin
         step(1'b0);
         if (arr_v && arr_cnt == 3) begin
            seen3++;
            checks++;
            if (o_next_en !== 1'b0 || o_retire !== 1'b0) begin
               errors++;
               $display("FAIL recirc_at_3 next_en=%b retire=%b required 0 0", o_next_en, o_retire);
            end
         end
         if (arr_v && arr_cnt == 4) begin
            seen4++;
            checks++;
            if (o_retire !== 1'b1 || o_next_en !== 1'b1) begin
               errors++;
               $display("FAIL retire_at_4 retire=%b next_en=%b required 1 1", o_retire, o_next_en);
            end
         end
         if (o_done === 1'b1) finished = 1'b1;
      end
      checks++;
      if (!finished || seen3 != TOT || seen4 != TOT) begin
         errors++;
         $display("FAIL block_limit_frame done=%b at3=%0d at4=%0d required 1 %0d %0d", finished, seen3, seen4, TOT, TOT);
      end
   endtask

   task automatic test_overrun();
      bit finished = 1'b0;
      hit_lap = 2;
      step(1'b1);
      for (int i = 0; i < 100 && m_issued < TOT; i++) step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      checks++;
      if (o_over !== 1'b1 || o_issued !== 20'(TOT) || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL overrun_in_drain overrun=%b issued=%0d busy=%b required 1 %0d 1", o_over, o_issued, o_busy, TOT);
      end
      for (int i = 0; i < 100 && !finished; i++) begin
         step(1'b0);
         checks++;
         if (o_done !== e_done) begin
            errors++;
            $display("FAIL overrun_done_timing cyc=%0d frame_done=%b required %b", cyc, o_done, e_done);
         end
         if (o_done === 1'b1) finished = 1'b1;
      end
      checks++;
      if (!finished || frame_overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_frame_end done=%b overrun=%b required 1 1", finished, frame_overrun);
      end
      step(1'b1);
      step(1'b0);
      checks++;
      if (o_issued !== 20'd0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL second_frame issued=%0d busy=%b required 0 1", o_issued, o_busy);
      end
   endtask

   task automatic test_mid_reset();
      hit_lap = 2;
      for (int i = 0; i < 100 && m_issued < 5; i++) step(1'b0);
      checks++;
      if (issued_cnt !== 20'd5) begin
         errors++;
         $display("FAIL pre_reset_issued got=%0d required 5", issued_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      checks++;
      if (frame_busy !== 1'b0 || frame_overrun !== 1'b0 || issued_cnt !== 20'd0 || inflight_cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset busy=%b overrun=%b issued=%0d inflight=%0d required 0 0 0 0",
                  frame_busy, frame_overrun, issued_cnt, inflight_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0);
         checks++;
         if (o_done !== 1'b0 || o_ev !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle done=%b entry_valid=%b busy=%b required 0 0 0", o_done, o_ev, o_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_block_limit();
      test_overrun();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end
endmodule
